instr_prefetch: RTL

INSTR_PREFETCH -- requirements
Module: instr_prefetch

---
 rtl/instr_prefetch_pkg.sv | 16 +
 rtl/instr_slot_ring.sv | 90 +++++++++
 rtl/instr_prefetch.sv | 99 +++++++++
 3 files changed

// File: rtl/instr_prefetch_pkg.sv
// Shared prefetch definitions: default geometry, reset fetch address,
// instruction stride and the per-slot payload layout.
package instr_prefetch_pkg;

    localparam int unsigned XLEN         = 32;
    localparam int unsigned PF_DEPTH     = 4;
    localparam logic [31:0] PF_RESET_PC  = 32'h0000_0000;
    localparam logic [31:0] INSTR_STRIDE = 32'd4;

    // Slot payload; the filled flag sits beside it in a resettable bit vector.
    typedef struct packed {
        logic [XLEN-1:0] pc;
        logic [XLEN-1:0] instr;
    } slot_t;

endpackage

// File: rtl/instr_slot_ring.sv
// In-order slot ring for the prefetcher. Slots are allocated at issue,
// filled in allocation order as responses return, and popped from the head.
// Ports:
//   clk, rst_n      clock, async active-low reset
//   flush_i         free every slot (wins over alloc/fill/pop)
//   alloc_i/_pc_i   allocate a slot at the tail with its fetch PC
//   fill_i/_instr_i fill the oldest unfilled slot with a response word
//   pop_i           consume the head slot if it is filled
//   count_o         allocated slots
//   pending_o       allocated but not yet filled slots
//   head_valid_o    head slot allocated and filled
//   head_pc_o/_instr_o  head slot contents
module instr_slot_ring
    import instr_prefetch_pkg::*;
#(
    parameter int unsigned DEPTH = PF_DEPTH
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   flush_i,
    input  logic                   alloc_i,
    input  logic [XLEN-1:0]        alloc_pc_i,
    input  logic                   fill_i,
    input  logic [XLEN-1:0]        fill_instr_i,
    input  logic                   pop_i,
    output logic [$clog2(DEPTH):0] count_o,
    output logic [$clog2(DEPTH):0] pending_o,
    output logic                   head_valid_o,
    output logic [XLEN-1:0]        head_pc_o,
    output logic [XLEN-1:0]        head_instr_o
);

    localparam int unsigned PW = $clog2(DEPTH);
    localparam int unsigned CW = PW + 1;

    // Pointers carry one extra wrap bit so full and empty are distinguishable.
    logic [CW-1:0]    alloc_ptr_q, fill_ptr_q, head_ptr_q;
    logic [DEPTH-1:0] filled_q;
    slot_t            slots_q [DEPTH];

    logic [CW-1:0] count, pending;
    logic [PW-1:0] alloc_idx, fill_idx, head_idx;
    logic          alloc_en, fill_en, pop_en, head_valid;

    assign count     = alloc_ptr_q - head_ptr_q;
    assign pending   = alloc_ptr_q - fill_ptr_q;
    assign alloc_idx = alloc_ptr_q[PW-1:0];
    assign fill_idx  = fill_ptr_q[PW-1:0];
    assign head_idx  = head_ptr_q[PW-1:0];

    assign alloc_en   = alloc_i & ~flush_i & (count < CW'(DEPTH));
    // A fill with nothing awaiting one is a protocol violation and is dropped.
    assign fill_en    = fill_i & ~flush_i & (pending != '0);
    assign head_valid = (count != '0) & filled_q[head_idx];
    assign pop_en     = pop_i & ~flush_i & head_valid;

    // Pointer and filled-bit state.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            alloc_ptr_q <= '0;
            fill_ptr_q  <= '0;
            head_ptr_q  <= '0;
            filled_q    <= '0;
        end else if (flush_i) begin
            alloc_ptr_q <= '0;
            fill_ptr_q  <= '0;
            head_ptr_q  <= '0;
            filled_q    <= '0;
        end else begin
            if (alloc_en) alloc_ptr_q <= alloc_ptr_q + CW'(1);
            if (fill_en)  fill_ptr_q  <= fill_ptr_q + CW'(1);
            if (pop_en)   head_ptr_q  <= head_ptr_q + CW'(1);
            if (fill_en)  filled_q[fill_idx] <= 1'b1;
            if (pop_en)   filled_q[head_idx] <= 1'b0;
        end
    end

    // Slot payload; only ever read when the filled bit qualifies it.
    always_ff @(posedge clk) begin
        if (alloc_en) slots_q[alloc_idx].pc    <= alloc_pc_i;
        if (fill_en)  slots_q[fill_idx].instr  <= fill_instr_i;
    end

    assign count_o      = count;
    assign pending_o    = pending;
    assign head_valid_o = head_valid;
    assign head_pc_o    = slots_q[head_idx].pc;
    assign head_instr_o = slots_q[head_idx].instr;

endmodule

// File: rtl/instr_prefetch.sv
// Instruction prefetcher: issues sequential word fetches into a DEPTH-entry
// slot ring, presents the oldest returned instruction to the core, and on a
// redirect flushes the ring and drops responses still in flight.
// Ports:
//   clk, reset                  clock, async active-low reset
//   redirect_valid/redirect_pc  flush and jump request from the core
//   imem_req/imem_addr          fetch request and word-aligned address
//   imem_gnt                    memory accepts the request this cycle
//   imem_rvalid/imem_rdata      in-order response word
//   out_valid/out_ready         head instruction handshake with the core
//   out_pc/out_instr            head instruction PC and word
module instr_prefetch
    import instr_prefetch_pkg::*;
#(
    parameter int unsigned DEPTH    = PF_DEPTH,
    parameter logic [31:0] RESET_PC = PF_RESET_PC
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_gnt,
    input  logic        imem_rvalid,
    input  logic [31:0] imem_rdata,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_pc,
    output logic [31:0] out_instr
);

    localparam int unsigned CW  = $clog2(DEPTH) + 1;
    localparam int unsigned DCW = 8;

    logic [31:0]    fetch_pc_q, fetch_pc_d;
    logic [DCW-1:0] discard_q, discard_d;

    logic [CW-1:0] ring_count, ring_pending;
    logic          head_valid;
    logic [31:0]   head_pc, head_instr;
    logic          issue, discarding, fill, rsp_consumed;

    // Request drops combinationally on reset and on a redirect.
    assign imem_req     = reset & ~redirect_valid & (ring_count < CW'(DEPTH));
    assign imem_addr    = fetch_pc_q;
    assign issue        = imem_req & imem_gnt;
    assign discarding   = (discard_q != '0);
    assign fill         = imem_rvalid & ~discarding & ~redirect_valid;
    // A response retires a discard first, otherwise an awaiting slot.
    assign rsp_consumed = imem_rvalid & (discarding | (ring_pending != '0));

    // Fetch address and in-flight discard accounting.
    always_comb begin
        fetch_pc_d = fetch_pc_q;
        discard_d  = discard_q;
        if (redirect_valid) begin
            fetch_pc_d = {redirect_pc[31:2], 2'b00};
            discard_d  = discard_q + DCW'(ring_pending) + DCW'(issue) - DCW'(rsp_consumed);
        end else begin
            if (issue) fetch_pc_d = fetch_pc_q + INSTR_STRIDE;
            if (imem_rvalid && discarding) discard_d = discard_q - DCW'(1);
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            fetch_pc_q <= RESET_PC;
            discard_q  <= '0;
        end else begin
            fetch_pc_q <= fetch_pc_d;
            discard_q  <= discard_d;
        end
    end

    instr_slot_ring #(
        .DEPTH (DEPTH)
    ) u_ring (
        .clk          (clk),
        .rst_n        (reset),
        .flush_i      (redirect_valid),
        .alloc_i      (issue),
        .alloc_pc_i   (fetch_pc_q),
        .fill_i       (fill),
        .fill_instr_i (imem_rdata),
        .pop_i        (out_ready),
        .count_o      (ring_count),
        .pending_o    (ring_pending),
        .head_valid_o (head_valid),
        .head_pc_o    (head_pc),
        .head_instr_o (head_instr)
    );

    // Head contents are masked so the outputs read zero whenever nothing is valid.
    assign out_valid = head_valid;
    assign out_pc    = head_valid ? head_pc : '0;
    assign out_instr = head_valid ? head_instr : '0;

endmodule
